// File: rtl/env_step_if.sv
// env_step_if: bundles the action handshake and the result bus of the
// grid-world step unit.
//   master : the action source / control side (drives start_state, done,
//            act_valid, act; observes everything else)
//   slave  : the env_step_unit itself
// Signals:
//   start_state       episode start state
//   done              control unit finished; blocks new actions
//   act_valid/act     offered action (0 up, 1 right, 2 down, 3 left)
//   act_ready         unit can take an action this cycle
//   cur_state         agent's current state
//   next_state/reward result of the last step, valid with res_valid
//   res_valid         one-cycle result strobe
//   terminal          qualifies res_valid: the step ended the episode
//   change_iteration  one-cycle episode-end pulse
//   ep_steps          steps taken in the current episode
interface env_step_if #(
  parameter int SW = 4
);
  logic [SW-1:0]      start_state;
  logic               done;
  logic               act_valid;
  logic [1:0]         act;
  logic               act_ready;
  logic [SW-1:0]      cur_state;
  logic [SW-1:0]      next_state;
  logic signed [7:0]  reward;
  logic               res_valid;
  logic               terminal;
  logic               change_iteration;
  logic [7:0]         ep_steps;

  modport master (
    output start_state, done, act_valid, act,
    input  act_ready, cur_state, next_state, reward, res_valid,
           terminal, change_iteration, ep_steps
  );

  modport slave (
    input  start_state, done, act_valid, act,
    output act_ready, cur_state, next_state, reward, res_valid,
           terminal, change_iteration, ep_steps
  );
endinterface

// File: rtl/env_step_unit.sv
// env_step_unit: grid-world environment step for a Q-learning controller.
// Takes one action at a time, moves the agent on a 2^GRID_BITS square grid,
// produces the next state and a signed 8-bit reward, counts steps in the
// episode and pulses change_iteration when the goal is reached or the step
// budget runs out. The agent then restarts at start_state.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  env_step_if.slave (action handshake in, step result out)
module env_step_unit #(
  parameter int                 GRID_BITS    = 2,
  parameter int                 GOAL_STATE   = 15,
  parameter int                 MAX_STEPS    = 64,
  parameter logic signed [7:0]  GOAL_REWARD  = 8'sd100,
  parameter logic signed [7:0]  WALL_PENALTY = -8'sd10,
  parameter logic signed [7:0]  STEP_PENALTY = -8'sd1
) (
  input  logic        clk,
  input  logic        rst,
  env_step_if.slave   bus
);

  localparam int SW = 2 * GRID_BITS;
  localparam logic [GRID_BITS-1:0] EDGE_LO = '0;
  localparam logic [GRID_BITS-1:0] EDGE_HI = '1;
  localparam logic [GRID_BITS-1:0] ONE     = GRID_BITS'(1);

  typedef enum logic [1:0] {S_WAIT, S_CALC, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         act_q, act_d;
  logic [SW-1:0]      cur_state_q, cur_state_d;
  logic [SW-1:0]      next_state_q, next_state_d;
  logic signed [7:0]  reward_q, reward_d;
  logic [7:0]         ep_steps_q, ep_steps_d;
  logic               act_ready_q, act_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               terminal_q, terminal_d;
  logic               chg_q, chg_d;

  logic [GRID_BITS-1:0] row, col;
  logic [SW-1:0]        cand;
  logic                 wall;
  logic                 term_calc;
  logic signed [7:0]    reward_calc;

  assign row = cur_state_q[SW-1:GRID_BITS];
  assign col = cur_state_q[GRID_BITS-1:0];

  // Candidate move; a move off the edge leaves the agent in place.
  always_comb begin
    cand = cur_state_q;
    wall = 1'b0;
    case (act_q)
      2'd0: if (row == EDGE_LO) wall = 1'b1; else cand = {row - ONE, col};
      2'd1: if (col == EDGE_HI) wall = 1'b1; else cand = {row, col + ONE};
      2'd2: if (row == EDGE_HI) wall = 1'b1; else cand = {row + ONE, col};
      default: if (col == EDGE_LO) wall = 1'b1; else cand = {row, col - ONE};
    endcase
    if (wall)                           reward_calc = WALL_PENALTY;
    else if (cand == SW'(GOAL_STATE))   reward_calc = GOAL_REWARD;
    else                                reward_calc = STEP_PENALTY;
    // A wall bump at the goal still counts as landing on it.
    term_calc = (cand == SW'(GOAL_STATE)) ||
                (({1'b0, ep_steps_q} + 9'd1) == 9'(MAX_STEPS));
  end

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    cur_state_d  = cur_state_q;
    next_state_d = next_state_q;
    reward_d     = reward_q;
    ep_steps_d   = ep_steps_q;
    act_ready_d  = 1'b0;
    res_valid_d  = 1'b0;
    terminal_d   = 1'b0;
    chg_d        = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (bus.act_valid && act_ready_q) begin
          act_d   = bus.act;
          state_d = S_CALC;
        end else begin
          act_ready_d = ~bus.done;
        end
      end
      S_CALC: begin
        next_state_d = cand;
        reward_d     = reward_calc;
        res_valid_d  = 1'b1;
        terminal_d   = term_calc;
        chg_d        = term_calc;
        state_d      = S_OUT;
      end
      S_OUT: begin
        if (terminal_q) begin
          cur_state_d = bus.start_state;
          ep_steps_d  = 8'd0;
        end else begin
          cur_state_d = next_state_q;
          ep_steps_d  = ep_steps_q + 8'd1;
        end
        act_ready_d = ~bus.done;
        state_d     = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT;
      act_q        <= 2'd0;
      cur_state_q  <= bus.start_state;
      next_state_q <= '0;
      reward_q     <= 8'sd0;
      ep_steps_q   <= 8'd0;
      act_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      terminal_q   <= 1'b0;
      chg_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      cur_state_q  <= cur_state_d;
      next_state_q <= next_state_d;
      reward_q     <= reward_d;
      ep_steps_q   <= ep_steps_d;
      act_ready_q  <= act_ready_d;
      res_valid_q  <= res_valid_d;
      terminal_q   <= terminal_d;
      chg_q        <= chg_d;
    end
  end

  assign bus.act_ready        = act_ready_q;
  assign bus.cur_state        = cur_state_q;
  assign bus.next_state       = next_state_q;
  assign bus.reward           = reward_q;
  assign bus.res_valid        = res_valid_q;
  assign bus.terminal         = terminal_q;
  assign bus.change_iteration = chg_q;
  assign bus.ep_steps         = ep_steps_q;

endmodule

// File: tb/tb_env_step_unit.sv
// Testbench for env_step_unit: directed scenarios plus a random walk,
// compared against a grid-arithmetic reference model.
module tb_env_step_unit;
  localparam int GB   = 2;
  localparam int SW   = 2 * GB;
  localparam int N    = 1 << GB;
  localparam int GOAL = 15;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  env_step_if #(.SW(SW)) bus ();

  env_step_unit #(
    .GRID_BITS(GB), .GOAL_STATE(GOAL), .MAX_STEPS(MAXS),
    .GOAL_REWARD(8'sd100), .WALL_PENALTY(-8'sd10), .STEP_PENALTY(-8'sd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_cur, m_steps, m_start;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic do_reset(input int start, input int cycles);
    @(negedge clk);
    rst = 1'b1;
    bus.start_state = SW'(start);
    bus.act_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_cur", 32'(bus.cur_state), 32'(start));
      chk("rst_rdy", 32'(bus.act_ready), 0);
      chk("rst_rv", 32'(bus.res_valid), 0);
      chk("rst_chg", 32'(bus.change_iteration), 0);
      chk("rst_steps", 32'(bus.ep_steps), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 32'(bus.act_ready), 1);
    m_cur = start; m_steps = 0; m_start = start;
  endtask

  // One step: offer action, check result two cycles after accept, then
  // check the updated agent position.
  task automatic do_step(input logic [1:0] a);
    int k, r, c, nr, nc, nxt, rew;
    bit term;
    logic [7:0] er;
    k = 0;
    while (!bus.act_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.act_ready) begin
      chk("ready_timeout", 32'(bus.act_ready), 1);
      return;
    end
    bus.act_valid = 1'b1;
    bus.act = a;
    @(negedge clk);
    bus.act_valid = 1'b0;
    bus.act = 2'($urandom_range(0, 3));
    chk("rv_early", 32'(bus.res_valid), 0);
    chk("rdy_busy", 32'(bus.act_ready), 0);

    r = m_cur / N; c = m_cur % N; nr = r; nc = c;
    case (a)
      2'd0: nr = r - 1;
      2'd1: nc = c + 1;
      2'd2: nr = r + 1;
      default: nc = c - 1;
    endcase
    if (nr < 0 || nr >= N || nc < 0 || nc >= N) begin
      nxt = m_cur; rew = -10;
    end else begin
      nxt = nr * N + nc;
      rew = (nxt == GOAL) ? 100 : -1;
    end
    term = (nxt == GOAL) || (m_steps + 1 == MAXS);
    er = rew[7:0];

    @(negedge clk);
    chk("res_valid", 32'(bus.res_valid), 1);
    chk("next_state", 32'(bus.next_state), 32'(nxt));
    chk("reward", {24'b0, bus.reward}, {24'b0, er});
    chk("terminal", 32'(bus.terminal), 32'(term));
    chk("chg_iter", 32'(bus.change_iteration), 32'(term));

    if (term) begin m_cur = m_start; m_steps = 0; end
    else begin m_cur = nxt; m_steps = m_steps + 1; end

    @(negedge clk);
    chk("rv_pulse", 32'(bus.res_valid), 0);
    chk("chg_pulse", 32'(bus.change_iteration), 0);
    chk("cur_state", 32'(bus.cur_state), 32'(m_cur));
    chk("ep_steps", 32'(bus.ep_steps), 32'(m_steps));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_state = '0;
    bus.done = 1'b0;
    bus.act_valid = 1'b0;
    bus.act = 2'd0;
    m_cur = 0; m_steps = 0; m_start = 0;

    // Reset, then right from 0.
    do_reset(0, 3);
    do_step(2'd1);
    // Wall bump up from 0.
    do_reset(0, 1);
    do_step(2'd0);
    // Goal from 14.
    do_reset(14, 1);
    do_step(2'd1);
    // Timeout: four wall bumps from 0.
    do_reset(0, 1);
    for (int i = 0; i < 4; i++) do_step(2'd0);
    // Goal is itself the start: wall bump at goal ends the episode.
    do_reset(15, 1);
    do_step(2'd1);

    // done blocks new actions.
    do_reset(0, 1);
    bus.done = 1'b1;
    @(negedge clk);
    bus.act_valid = 1'b1;
    bus.act = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("done_rdy", 32'(bus.act_ready), 0);
      chk("done_rv", 32'(bus.res_valid), 0);
    end
    bus.act_valid = 1'b0;
    bus.done = 1'b0;
    @(negedge clk);
    chk("done_cur", 32'(bus.cur_state), 0);
    do_step(2'd2);

    // Reset while an action is in flight.
    bus.act_valid = 1'b1;
    bus.act = 2'd1;
    @(negedge clk);
    bus.act_valid = 1'b0;
    rst = 1'b1;
    bus.start_state = SW'(5);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_rv", 32'(bus.res_valid), 0);
      chk("abort_cur", 32'(bus.cur_state), 5);
      chk("abort_steps", 32'(bus.ep_steps), 0);
    end
    chk("abort_rdy", 32'(bus.act_ready), 1);
    m_cur = 5; m_steps = 0; m_start = 5;
    do_step(2'd3);

    // Random walk with occasional new start states.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        m_start = int'($urandom_range(0, N * N - 1));
        bus.start_state = SW'(m_start);
      end
      do_step(2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
